// File: rtl/mfcc_melbank_acc.sv
// Mel filter energy accumulator: multiplies each power bin by its coefficient-ROM word and sums them over a frame.
// Optional macro MELBANK_ACC_SAT_EN makes the narrowed output saturate instead of wrap. ROM_LAT must be 1 or 2.
module mfcc_melbank_acc #(
   parameter int ADDR_WIDTH = 9,
   parameter int COEF_WIDTH = 8,
   parameter int POW_WIDTH  = 32,
   parameter int NUM_BINS   = 257,
   parameter int ROM_LAT    = 1,
   parameter int OUT_WIDTH  = 32,
   parameter int SHIFT      = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [POW_WIDTH-1:0]  in_data,
   input  logic                  in_last,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [COEF_WIDTH-1:0] rom_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  frame_err
);

   localparam int PROD_WIDTH = POW_WIDTH + COEF_WIDTH;
   localparam int ACC_WIDTH  = POW_WIDTH + COEF_WIDTH + ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

   typedef enum logic [1:0] {
      ST_ACCUM,
      ST_DRAIN,
      ST_HOLD
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;
   logic                    w_beat;
   logic                    w_frame_end;
   logic [ADDR_WIDTH-1:0]   r_bin_cnt;
   logic                    r_err_pend;

   logic [POW_WIDTH-1:0]    r_dly_data  [ROM_LAT];
   logic                    r_dly_vld   [ROM_LAT];
   logic                    r_dly_last  [ROM_LAT];
   logic                    r_dly_first [ROM_LAT];

   logic [PROD_WIDTH-1:0]   r_prod;
   logic                    r_p_vld;
   logic                    r_p_last;
   logic                    r_p_first;

   logic [ACC_WIDTH-1:0]    r_acc;
   logic                    r_a_last;
   logic [OUT_WIDTH-1:0]    w_out;

   assign w_beat      = in_valid & in_ready;
   // A frame ends on in_last, or when the bin counter hits the last bin even without in_last.
   assign w_frame_end = w_beat & (in_last | (r_bin_cnt == LAST_BIN));

   // NOTE: state and datapath registers use non-blocking assignments and the async reset in the
   // sensitivity list, so every flop sees pre-edge values regardless of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_ACCUM;
      else        r_state <= w_next_state;
   end

   // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (w_frame_end) w_next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_a_last) w_next_state = ST_HOLD;
         end
         ST_HOLD: begin
            // out_valid has already dropped after the handshake: this is the single bubble cycle.
            if (!out_valid) w_next_state = ST_ACCUM;
         end
         default: w_next_state = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin_cnt  <= '0;
         r_err_pend <= 1'b0;
         rom_addr   <= '0;
      end else if (w_beat) begin
         rom_addr  <= r_bin_cnt;
         r_bin_cnt <= w_frame_end ? '0 : r_bin_cnt + ADDR_WIDTH'(1);
         if (w_frame_end) r_err_pend <= ~in_last | (r_bin_cnt != LAST_BIN);
      end
   end

   // Power and frame flags wait ROM_LAT cycles so they meet the coefficient for the same bin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            r_dly_data[i]  <= '0;
            r_dly_vld[i]   <= 1'b0;
            r_dly_last[i]  <= 1'b0;
            r_dly_first[i] <= 1'b0;
         end
      end else begin
         r_dly_data[0]  <= in_data;
         r_dly_vld[0]   <= w_beat;
         r_dly_last[0]  <= w_frame_end;
         r_dly_first[0] <= (r_bin_cnt == '0);
         for (int i = 1; i < ROM_LAT; i++) begin
            r_dly_data[i]  <= r_dly_data[i-1];
            r_dly_vld[i]   <= r_dly_vld[i-1];
            r_dly_last[i]  <= r_dly_last[i-1];
            r_dly_first[i] <= r_dly_first[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod    <= '0;
         r_p_vld   <= 1'b0;
         r_p_last  <= 1'b0;
         r_p_first <= 1'b0;
      end else begin
         r_prod    <= PROD_WIDTH'(r_dly_data[ROM_LAT-1]) * PROD_WIDTH'(rom_data);
         r_p_vld   <= r_dly_vld[ROM_LAT-1];
         r_p_last  <= r_dly_vld[ROM_LAT-1] & r_dly_last[ROM_LAT-1];
         r_p_first <= r_dly_first[ROM_LAT-1];
      end
   end

   // The first product of a frame overwrites the accumulator, so no separate clear cycle is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_a_last <= 1'b0;
      end else begin
         r_a_last <= r_p_vld & r_p_last;
         if (r_p_vld) r_acc <= r_p_first ? ACC_WIDTH'(r_prod) : r_acc + ACC_WIDTH'(r_prod);
      end
   end

`ifdef MELBANK_ACC_SAT_EN
   logic [ACC_WIDTH-1:0] w_shifted;
   logic                 w_overflow;
   assign w_shifted  = r_acc >> SHIFT;
   assign w_overflow = |(w_shifted >> OUT_WIDTH);
   assign w_out      = w_overflow ? '1 : OUT_WIDTH'(w_shifted);
`else
   assign w_out      = OUT_WIDTH'(r_acc >> SHIFT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         frame_err <= 1'b0;
      end else if (r_state == ST_DRAIN && r_a_last) begin
         out_valid <= 1'b1;
         out_data  <= w_out;
         frame_err <= r_err_pend;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mfcc_melbank_acc.sv
// Scoreboard bench for mfcc_melbank_acc: one instance with ROM_LAT=1, one with ROM_LAT=2, both on an addr[7:0] ROM model.
module tb_mfcc_melbank_acc;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid1, in_ready1, in_last1, out_valid1, out_ready1, frame_err1;
   logic [31:0] in_data1, out_data1;
   logic [8:0]  rom_addr1;
   logic [7:0]  rom_data1;

   logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, frame_err2;
   logic [31:0] in_data2, out_data2;
   logic [8:0]  rom_addr2;
   logic [7:0]  rom_data2, rom_q2;

   assign rom_data1 = rom_addr1[7:0];
   always @(posedge clk) rom_q2 <= rom_addr2[7:0];
   assign rom_data2 = rom_q2;

   mfcc_melbank_acc #(.ROM_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .in_last(in_last1), .rom_addr(rom_addr1), .rom_data(rom_data1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_data(out_data1), .frame_err(frame_err1));

   mfcc_melbank_acc #(.ROM_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
      .in_last(in_last2), .rom_addr(rom_addr2), .rom_data(rom_data2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_data(out_data2), .frame_err(frame_err2));

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          cyc;
      int          lat;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   n_checks = 0;
   int   errors   = 0;
   int   cyc      = 0;
   logic        pv[2];
   logic        pr[2];
   logic [31:0] pd[2];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mon(input int s, input logic v, input logic r, input logic [31:0] d, input logic e);
      exp_t x;
      if (v && !pv[s]) begin
         if ((s == 0) ? (q1.size() == 0) : (q2.size() == 0)) begin
            n_checks++;
            errors++;
            $display("FAIL unexpected_output dut%0d: got %0h expected none", s + 1, d);
         end else begin
            x = (s == 0) ? q1.pop_front() : q2.pop_front();
            check($sformatf("out_data dut%0d", s + 1), 64'(d), 64'(x.d));
            check($sformatf("frame_err dut%0d", s + 1), 64'(e), 64'(x.e));
            check($sformatf("latency dut%0d", s + 1), 64'(cyc - x.cyc), 64'(x.lat));
         end
      end else if (v && pv[s] && !pr[s]) begin
         check($sformatf("hold_stable dut%0d", s + 1), 64'(d), 64'(pd[s]));
      end
      pv[s] = v;
      pr[s] = r;
      pd[s] = d;
   endtask

   always @(negedge clk) mon(0, out_valid1, out_ready1, out_data1, frame_err1);
   always @(negedge clk) mon(1, out_valid2, out_ready2, out_data2, frame_err2);

   task automatic drive(input int s, input logic v, input logic [31:0] d, input logic l);
      if (s == 0) begin in_valid1 = v; in_data1 = d; in_last1 = l; end
      else        begin in_valid2 = v; in_data2 = d; in_last2 = l; end
   endtask

   // Sends n bins of value val; in_last on bin last_idx (-1 for none); optional 50% idle gaps.
   task automatic send_frame(input int s, input int n, input logic [31:0] val, input int last_idx,
                             input bit gaps, input bit push, input logic [31:0] exp_d, input bit exp_e);
      exp_t x;
      int   t;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            drive(s, 1'b0, 32'h0, 1'b0);
            @(posedge clk); #1;
         end
         drive(s, 1'b1, val, i == last_idx);
         t = 0;
         while (((s == 0) ? in_ready1 : in_ready2) !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
         end
         if (t >= 100) check("in_ready_timeout", 64'(t), 64'd0);
         @(posedge clk); #1;
      end
      drive(s, 1'b0, 32'h0, 1'b0);
      if (push) begin
         x.d   = exp_d;
         x.e   = exp_e;
         x.cyc = cyc;
         x.lat = (s == 0) ? 3 : 4;
         if (s == 0) q1.push_back(x);
         else        q2.push_back(x);
      end
   endtask

   task automatic wait_drain(input int s);
      int t = 0;
      while (((s == 0) ? q1.size() : q2.size()) != 0 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      check($sformatf("drain dut%0d", s + 1), 64'((s == 0) ? q1.size() : q2.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] GOOD = 32'd32640000;
`ifdef MELBANK_ACC_SAT_EN
   localparam logic [31:0] BIG_EXP = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] BIG_EXP = 32'hFFFF_8080;
`endif

   initial begin
      int t;
      rst_n = 1'b0;
      drive(0, 1'b0, 32'h0, 1'b0);
      drive(1, 1'b0, 32'h0, 1'b0);
      out_ready1 = 1'b1;
      out_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst out_valid", 64'(out_valid1), 64'd0);
      check("rst out_data", 64'(out_data1), 64'd0);
      check("rst frame_err", 64'(frame_err1), 64'd0);
      check("rst rom_addr", 64'(rom_addr1), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst in_ready", 64'(in_ready1), 64'd1);

      // Nominal frame, then an all-ones frame that overflows the 32-bit output.
      send_frame(0, 257, 32'd1000, 256, 1'b0, 1'b1, GOOD, 1'b0);
      wait_drain(0);
      send_frame(0, 257, 32'hFFFF_FFFF, 256, 1'b0, 1'b1, BIG_EXP, 1'b0);
      wait_drain(0);

      // Output back-pressure with input pushing against it.
      out_ready1 = 1'b0;
      send_frame(0, 257, 32'd1000, 256, 1'b0, 1'b1, GOOD, 1'b0);
      drive(0, 1'b1, 32'd5, 1'b0);
      t = 0;
      while (out_valid1 !== 1'b1 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      check("stall out_valid", 64'(out_valid1), 64'd1);
      for (int i = 0; i < 20; i++) begin
         check("stall in_ready", 64'(in_ready1), 64'd0);
         @(posedge clk); #1;
      end
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      check("bubble in_ready", 64'(in_ready1), 64'd0);
      check("bubble out_valid", 64'(out_valid1), 64'd0);
      drive(0, 1'b0, 32'h0, 1'b0);
      @(posedge clk); #1;
      check("resume in_ready", 64'(in_ready1), 64'd1);
      wait_drain(0);

      // Short frame, good frame, then a frame with no in_last (bin 256 closes it).
      send_frame(0, 10, 32'd1000, 9, 1'b0, 1'b1, 32'd45000, 1'b1);
      wait_drain(0);
      send_frame(0, 257, 32'd1000, 256, 1'b0, 1'b1, GOOD, 1'b0);
      wait_drain(0);
      send_frame(0, 257, 32'd1000, -1, 1'b0, 1'b1, GOOD, 1'b1);
      wait_drain(0);

      // Reset in the middle of a frame discards it entirely.
      send_frame(0, 100, 32'd1000, -1, 1'b0, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 64'(out_valid1), 64'd0);
      check("midrst acc", 64'(u_dut1.r_acc), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(0, 257, 32'd1000, 256, 1'b0, 1'b1, GOOD, 1'b0);
      wait_drain(0);

      // Two-cycle ROM with random input bubbles.
      send_frame(1, 257, 32'd1000, 256, 1'b1, 1'b1, GOOD, 1'b0);
      wait_drain(1);
      send_frame(1, 10, 32'd1000, 9, 1'b1, 1'b1, 32'd45000, 1'b1);
      wait_drain(1);

      $display("Result: errors=%0d of %0d checks", errors, n_checks);
      $finish;
   end

endmodule
